// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the 5-bit registered ALU: load A, load B, execute, capture,
// then hold the result on a valid/ready response channel.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// LOAD_A | alu_data = A, alu_load_a strobe
// LOAD_B | alu_data = B, alu_load_b strobe
// EXEC   | alu_enable_out strobe, ALU result register loads at end of cycle
// CAPT   | capture ALU result (or 0 for an illegal opcode) into rsp_data
// RESP   | rsp_valid high until rsp_ready
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_a,
  input  logic [4:0] cmd_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [9:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] op_count,
  output logic       alu_load_a,
  output logic       alu_load_b,
  output logic [4:0] alu_data,
  output logic [1:0] alu_op_sel,
  output logic       alu_enable_out,
  input  logic [9:0] alu_result
);

  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, CAPT, RESP} state_t;

  state_t     state;
  logic [1:0] op_q;
  logic [4:0] b_q;

  assign alu_op_sel = op_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      op_q           <= 2'b00;
      b_q            <= 5'd0;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_data       <= 10'd0;
      rsp_err        <= 1'b0;
      op_count       <= 8'd0;
      alu_load_a     <= 1'b0;
      alu_load_b     <= 1'b0;
      alu_data       <= 5'd0;
      alu_enable_out <= 1'b0;
    end else begin
      alu_load_a     <= 1'b0;
      alu_load_b     <= 1'b0;
      alu_enable_out <= 1'b0;
      alu_data       <= 5'd0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            b_q       <= cmd_b;
            cmd_ready <= 1'b0;
            // An illegal op spends one quiet cycle in CAPT so the ALU is never touched.
            if (cmd_op != OP_ILL) begin
              state      <= LOAD_A;
              alu_load_a <= 1'b1;
              alu_data   <= cmd_a;
            end else begin
              state <= CAPT;
            end
          end
        end
        LOAD_A: begin
          state      <= LOAD_B;
          alu_load_b <= 1'b1;
          alu_data   <= b_q;
        end
        LOAD_B: begin
          state          <= EXEC;
          alu_enable_out <= 1'b1;
        end
        EXEC: begin
          state <= CAPT;
        end
        CAPT: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= (op_q == OP_ILL);
          rsp_data  <= (op_q == OP_ILL) ? 10'd0 : alu_result;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            if (!rsp_err) op_count <= op_count + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: models alu_top, keeps a transaction-level reference of the
// controller, compares on every falling edge, and adds directed literal checks.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [4:0] cmd_a = 5'd0;
  logic [4:0] cmd_b = 5'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [9:0] rsp_data;
  logic       rsp_err;
  logic [7:0] op_count;
  logic       alu_load_a;
  logic       alu_load_b;
  logic [4:0] alu_data;
  logic [1:0] alu_op_sel;
  logic       alu_enable_out;
  logic [9:0] alu_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .op_count(op_count),
    .alu_load_a(alu_load_a), .alu_load_b(alu_load_b), .alu_data(alu_data),
    .alu_op_sel(alu_op_sel), .alu_enable_out(alu_enable_out), .alu_result(alu_result)
  );

  // alu_top stand-in: no reset, registers start with stale junk
  logic [4:0] alu_ra = 5'd17;
  logic [4:0] alu_rb = 5'd3;
  initial alu_result = 10'h2aa;
  always @(posedge clk) begin
    if (alu_load_a) alu_ra <= alu_data;
    if (alu_load_b) alu_rb <= alu_data;
    if (alu_enable_out)
      case (alu_op_sel)
        2'b00:   alu_result <= {5'd0, alu_ra + alu_rb};
        2'b01:   alu_result <= {5'd0, alu_ra - alu_rb};
        2'b10:   alu_result <= alu_ra * alu_rb;
        default: alu_result <= 10'd0;
      endcase
  end

  function automatic logic [9:0] golden(input logic [1:0] op, input int a, input int b);
    if (op == 2'b00) return 10'((a + b) % 32);
    if (op == 2'b01) return 10'((a - b + 32) % 32);
    if (op == 2'b10) return 10'(a * b);
    return 10'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: m_t counts cycles since acceptance; response is due after 4 (legal) or 1 (illegal).
  bit         m_busy;
  int         m_t;
  bit         m_legal;
  logic [4:0] m_a, m_b;
  logic [1:0] m_op;
  logic [9:0] m_res, m_rsp;
  bit         m_err;
  logic [7:0] m_cnt;
  bit         chk_en = 1'b0;

  function automatic int resp_at();
    return m_legal ? 4 : 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_t = 0; m_legal = 0; m_op = 0; m_a = 0; m_b = 0;
      m_rsp = 0; m_err = 0; m_cnt = 0; m_res = 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy = 1; m_t = 0; m_op = cmd_op; m_a = cmd_a; m_b = cmd_b;
        m_legal = (cmd_op != 2'b11);
        m_res = golden(cmd_op, int'(cmd_a), int'(cmd_b));
      end
    end else if (m_t >= resp_at()) begin
      if (rsp_ready) begin
        m_busy = 0;
        if (!m_err) m_cnt = m_cnt + 8'd1;
      end
    end else begin
      m_t = m_t + 1;
      if (m_t == resp_at()) begin
        m_rsp = m_legal ? m_res : 10'd0;
        m_err = !m_legal;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit la, lb, en;
      logic [4:0] d;
      la = m_busy && m_legal && m_t == 0;
      lb = m_busy && m_legal && m_t == 1;
      en = m_busy && m_legal && m_t == 2;
      d  = la ? m_a : (lb ? m_b : 5'd0);
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("rsp_valid", rsp_valid, m_busy && m_t >= resp_at());
      chk("rsp_data", rsp_data, m_rsp);
      chk("rsp_err", rsp_err, m_err);
      chk("op_count", op_count, m_cnt);
      chk("alu_load_a", alu_load_a, la);
      chk("alu_load_b", alu_load_b, lb);
      chk("alu_enable_out", alu_enable_out, en);
      chk("alu_data", alu_data, d);
      chk("alu_op_sel", alu_op_sel, m_op);
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [9:0] exp_d, input bit exp_e, input int hold,
                        input int exp_cnt);
    int n;
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 0;
    if (op != 2'b11) chk("strobe_a", {alu_load_a, alu_load_b, alu_enable_out, alu_data}, {3'b100, a});
    else chk("ill_quiet", {alu_load_a, alu_load_b, alu_enable_out, alu_data}, 0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk); n++;
      if (op != 2'b11 && n == 1) chk("strobe_b", {alu_load_a, alu_load_b, alu_enable_out, alu_data}, {3'b010, b});
      if (op != 2'b11 && n == 2) chk("strobe_en", {alu_load_a, alu_load_b, alu_enable_out, alu_data}, {3'b001, 5'd0});
    end
    chk("latency", n, (op == 2'b11) ? 1 : 4);
    chk("rsp_data_lit", rsp_data, exp_d);
    chk("rsp_err_lit", rsp_err, exp_e);
    if (hold > 0) begin
      cmd_valid = 1; cmd_op = 2'b00; cmd_a = 5'd1; cmd_b = 5'd2;
      repeat (hold) @(negedge clk);
      cmd_valid = 0;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, exp_d);
      chk("stall_ready", cmd_ready, 0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("op_count_lit", op_count, exp_cnt);
    chk("idle_ready", cmd_ready, 1);
  endtask

  task automatic b2b(input int cnt, input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
    int done, cyc, last, acc;
    done = 0; cyc = 0; last = -1; acc = 0;
    @(negedge clk);
    cmd_valid = 1; rsp_ready = 1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (done < cnt && cyc < cnt * 6 + 50) begin
      if (cmd_valid && cmd_ready) begin
        if (last >= 0 && acc < 3) chk("cadence", cyc - last, 6);
        last = cyc; acc++;
      end
      if (rsp_valid) begin
        done++;
        if (done == cnt) cmd_valid = 0;
      end
      @(negedge clk); cyc++;
    end
    if (done < cnt) chk("b2b_timeout", done, cnt);
    rsp_ready = 0;
  endtask

  initial begin
    #1 rst = 1;
    chk_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_outs", {rsp_valid, rsp_data, rsp_err, op_count, alu_load_a, alu_load_b,
                     alu_data, alu_op_sel, alu_enable_out}, 0);
    rst = 0;

    run_op(2'b00, 5'd20, 5'd15, 10'd3, 1'b0, 0, 1);
    run_op(2'b01, 5'd7, 5'd9, 10'd30, 1'b0, 0, 2);
    run_op(2'b10, 5'd31, 5'd31, 10'd961, 1'b0, 10, 3);
    run_op(2'b11, 5'd5, 5'd6, 10'd0, 1'b1, 0, 3);
    b2b(3, 2'b10, 5'd3, 5'd4);
    chk("b2b_count", op_count, 6);
    chk("b2b_data", rsp_data, 12);

    // reset in the LOAD_B cycle
    @(negedge clk);
    cmd_valid = 1; cmd_op = 2'b00; cmd_a = 5'd9; cmd_b = 5'd9;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    chk("pre_rst_ldb", alu_load_b, 1);
    #2 rst = 1;
    #1;
    chk("async_ready", cmd_ready, 1);
    chk("async_outs", {rsp_valid, rsp_data, rsp_err, op_count, alu_load_a, alu_load_b,
                       alu_data, alu_op_sel, alu_enable_out}, 0);
    @(negedge clk);
    rst = 0;
    run_op(2'b00, 5'd1, 5'd1, 10'd2, 1'b0, 0, 1);

    b2b(255, 2'b00, 5'd2, 5'd3);
    @(negedge clk);
    chk("wrap_count", op_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
